apb_timer_slave: RTL and testbench

- APB slave peripheral (down-counting timer with prescaler and interrupt) that sits directly downstream of the APB bus block.
- Consumes that block's shared `addr`, `wr_rd`, `wdata`, `wstrobe` and `enable`, plus its own `sel` bit.
- Returns `ready` and `rdata` on one `s2m_ready` / `s2m_data` slot of the bus.
- Programmable wait states exercise the bus's transfer-extension path.

---
 rtl/apb_timer_slave_if.sv | 18 +
 rtl/apb_timer_slave.sv | 147 ++++++++++++++
 tb/tb_apb_timer_slave.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_slave_if.sv
// Bus bundle between the APB bridge and the timer slave.
// Handshake: a transfer completes in the cycle where sel & enable & ready are all high; the master holds every request field stable until then.
interface apb_timer_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  sel;
    logic                  enable;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrobe;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output sel, enable, wr_rd, addr, wdata, wstrobe, input ready, rdata);
    modport slave  (input sel, enable, wr_rd, addr, wdata, wstrobe, output ready, rdata);
endinterface

// File: rtl/apb_timer_slave.sv
// APB slave down-counting timer with prescaler, auto-reload, W1C status and level irq.
// Optional APB_TIMER_WSTRB_EN: honour per-byte write strobes (default: full-word writes).
module apb_timer_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int COUNT_WIDTH    = 32,
    parameter int PRESCALE_WIDTH = 16,
    parameter int WAIT_STATES    = 0
) (
    input  logic              clk,
    input  logic              rst,
    apb_timer_slave_if.slave  bus,
    output logic              irq,
    output logic              dbg_state
);
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_e;

    localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WCW-1:0] WS_MAX = WCW'(WAIT_STATES);

    state_e                    state_q, state_d;
    logic [WCW-1:0]            wcnt_q, wcnt_d;
    logic                      armed_q, armed_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic [COUNT_WIDTH-1:0]    load_q, load_d, count_q, count_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d, pc_q, pc_d;
    logic                      expired_q, expired_d;

    logic                      access, ready_w, wr_commit, tick, expire;
    logic [2:0]                reg_sel;
    logic [31:0]               wmask, rd_mux;
    logic [2:0]                ctrl_w;
    logic [COUNT_WIDTH-1:0]    load_w;
    logic [PRESCALE_WIDTH-1:0] prescale_w;
    logic                      unused_ok;

    assign unused_ok = ^{bus.addr, bus.wdata, bus.wstrobe, wmask};

    always_comb begin
`ifdef APB_TIMER_WSTRB_EN
        wmask = {{8{bus.wstrobe[3]}}, {8{bus.wstrobe[2]}}, {8{bus.wstrobe[1]}}, {8{bus.wstrobe[0]}}};
`else
        wmask = '1;
`endif
    end

    // armed_q blocks a transfer that was already in flight across reset until the master drops it.
    assign access    = bus.sel & bus.enable;
    assign ready_w   = access & armed_q & (wcnt_q == WS_MAX);
    assign wr_commit = ready_w & bus.wr_rd;
    assign reg_sel   = bus.addr[4:2];
    assign bus.ready = ready_w;
    assign dbg_state = state_q;

    assign ctrl_w     = (ctrl_q & ~wmask[2:0]) | (bus.wdata[2:0] & wmask[2:0]);
    assign load_w     = (load_q & ~wmask[COUNT_WIDTH-1:0]) | (bus.wdata[COUNT_WIDTH-1:0] & wmask[COUNT_WIDTH-1:0]);
    assign prescale_w = (prescale_q & ~wmask[PRESCALE_WIDTH-1:0])
                      | (bus.wdata[PRESCALE_WIDTH-1:0] & wmask[PRESCALE_WIDTH-1:0]);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        armed_d = armed_q;
        if (!access) begin
            state_d = IDLE;
            wcnt_d  = '0;
            armed_d = 1'b1;
        end else if (!armed_q || ready_w) begin
            state_d = IDLE;
            wcnt_d  = '0;
        end else begin
            // Not ready while armed means wcnt_q is still below WS_MAX.
            state_d = ACC;
            wcnt_d  = wcnt_q + 1'b1;
        end
    end

    always_comb begin
        tick       = ctrl_q[0] & (pc_q == prescale_q);
        expire     = tick & (count_q == '0);
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        pc_d       = pc_q;
        expired_d  = expired_q;
        if (ctrl_q[0]) pc_d = tick ? '0 : pc_q + 1'b1;
        if (tick) begin
            if (count_q != '0)  count_d   = count_q - 1'b1;
            else if (ctrl_q[1]) count_d   = load_q;
            else                ctrl_d[0] = 1'b0;
        end
        // Software writes override the timer's own updates; expiry overrides W1C below.
        if (wr_commit) begin
            case (reg_sel)
                3'd0: ctrl_d = ctrl_w;
                3'd1: begin
                    load_d  = load_w;
                    count_d = load_w;
                    pc_d    = '0;
                end
                3'd3: prescale_d = prescale_w;
                3'd4: if (bus.wdata[0] & wmask[0]) expired_d = 1'b0;
                default: ;
            endcase
        end
        if (expire) expired_d = 1'b1;
    end

    always_comb begin
        case (reg_sel)
            3'd0:    rd_mux = {29'b0, ctrl_q};
            3'd1:    rd_mux = 32'(load_q);
            3'd2:    rd_mux = 32'(count_q);
            3'd3:    rd_mux = 32'(prescale_q);
            3'd4:    rd_mux = {31'b0, expired_q};
            default: rd_mux = '0;
        endcase
        bus.rdata = (ready_w & ~bus.wr_rd) ? rd_mux : '0;
    end

    assign irq = expired_q & ctrl_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            armed_q    <= 1'b0;
            ctrl_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            prescale_q <= '0;
            pc_q       <= '0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            armed_q    <= armed_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            pc_q       <= pc_d;
            expired_q  <= expired_d;
        end
    end
endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: a zero-wait instance and a two-wait-state instance share one driver.
module tb_apb_timer_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tgt = 1'b0;
    logic        d_sel = 1'b0, d_en = 1'b0, d_wr = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_strb = 4'hF;
    logic        irq0, irq2, dbg0, dbg2, rdy;
    logic [31:0] rdat, v;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    apb_timer_slave_if bus0 ();
    apb_timer_slave_if bus2 ();

    assign bus0.sel = d_sel & ~tgt;   assign bus2.sel = d_sel & tgt;
    assign bus0.enable = d_en;        assign bus2.enable = d_en;
    assign bus0.wr_rd = d_wr;         assign bus2.wr_rd = d_wr;
    assign bus0.addr = d_addr;        assign bus2.addr = d_addr;
    assign bus0.wdata = d_wdata;      assign bus2.wdata = d_wdata;
    assign bus0.wstrobe = d_strb;     assign bus2.wstrobe = d_strb;
    assign rdy  = tgt ? bus2.ready : bus0.ready;
    assign rdat = tgt ? bus2.rdata : bus0.rdata;

    apb_timer_slave #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .irq(irq0), .dbg_state(dbg0));
    apb_timer_slave #(.WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .irq(irq2), .dbg_state(dbg2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Driver tasks start just after a rising edge and return just after the completion edge.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        d_sel = 1'b1; d_en = 1'b0; d_wr = 1'b1; d_addr = a; d_wdata = d; d_strb = s;
        @(posedge clk); #1 d_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 8) begin @(negedge clk); n++; end
        check("wr_ready", {31'b0, rdy}, 32'd1);
        @(posedge clk); #1 d_sel = 1'b0; d_en = 1'b0; d_wr = 1'b0; d_strb = 4'hF;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        d_sel = 1'b1; d_en = 1'b0; d_wr = 1'b0; d_addr = a;
        @(posedge clk); #1 d_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 8) begin @(negedge clk); n++; end
        check("rd_ready", {31'b0, rdy}, 32'd1);
        d = rdat;
        @(posedge clk); #1 d_sel = 1'b0; d_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_irq", {31'b0, irq0}, 32'd0);
        check("rst_ready", {31'b0, rdy}, 32'd0);
        check("rst_state", {31'b0, dbg0}, 32'd0);
        @(posedge clk); #1;

        // Program something, then reset in the middle of a LOAD write
        apb_write(32'h04, 32'h1234, 4'hF);
        apb_write(32'h0C, 32'h7, 4'hF);
        apb_write(32'h00, 32'h4, 4'hF);
        apb_read(32'h04, v); check("load_pre", v, 32'h1234);
        d_sel = 1'b1; d_en = 1'b0; d_wr = 1'b1; d_addr = 32'h04; d_wdata = 32'h99;
        @(posedge clk); #1 d_en = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, rdy}, 32'd0);
        @(posedge clk); #1 d_sel = 1'b0; d_en = 1'b0; d_wr = 1'b0;
        apb_read(32'h00, v); check("rst_ctrl", v, 32'h0);
        apb_read(32'h04, v); check("rst_load", v, 32'h0);
        apb_read(32'h08, v); check("rst_count", v, 32'h0);
        apb_read(32'h0C, v); check("rst_prescale", v, 32'h0);
        apb_read(32'h10, v); check("rst_status", v, 32'h0);
        check("rst_irq2", {31'b0, irq0}, 32'd0);

        // One-shot: COUNT visible every cycle by holding the read access open
        apb_write(32'h0C, 32'h0, 4'hF);
        apb_write(32'h04, 32'h5, 4'hF);
        apb_write(32'h00, 32'h5, 4'hF);
        d_sel = 1'b1; d_en = 1'b1; d_wr = 1'b0; d_addr = 32'h08;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("oneshot_count", rdat, 32'(6 - k));
            check("oneshot_irq_low", {31'b0, irq0}, 32'd0);
        end
        @(negedge clk);
        check("oneshot_irq", {31'b0, irq0}, 32'd1);
        check("oneshot_hold", rdat, 32'd0);
        @(posedge clk); #1 d_sel = 1'b0; d_en = 1'b0;
        apb_read(32'h00, v); check("oneshot_ctrl", v, 32'h4);
        apb_read(32'h10, v); check("oneshot_status", v, 32'h1);

        // W1C: plain clear, then a clear colliding with expiry
        apb_write(32'h10, 32'h1, 4'hF);
        apb_read(32'h10, v); check("w1c_clear", v, 32'h0);
        check("w1c_irq_low", {31'b0, irq0}, 32'd0);
        apb_write(32'h04, 32'h2, 4'hF);
        apb_write(32'h00, 32'h5, 4'hF);
        @(posedge clk); #1;
        apb_write(32'h10, 32'h1, 4'hF);
        apb_read(32'h10, v); check("w1c_race", v, 32'h1);
        check("w1c_race_irq", {31'b0, irq0}, 32'd1);
        apb_write(32'h10, 32'h1, 4'hF);
        apb_read(32'h10, v); check("w1c_second", v, 32'h0);
        check("w1c_irq_fall", {31'b0, irq0}, 32'd0);

        // CTRL write lands on the same edge as the hardware run clear
        apb_write(32'h04, 32'h1, 4'hF);
        apb_write(32'h00, 32'h1, 4'hF);
        apb_write(32'h00, 32'h3, 4'hF);
        apb_read(32'h00, v); check("sw_wins_ctrl", v, 32'h3);
        apb_write(32'h00, 32'h0, 4'hF);
        apb_write(32'h10, 32'h1, 4'hF);

        // Auto-reload: PRESCALE=3, LOAD=2 -> 12-cycle period, irq masked
        apb_write(32'h0C, 32'h3, 4'hF);
        apb_write(32'h04, 32'h2, 4'hF);
        apb_write(32'h00, 32'h3, 4'hF);
        d_sel = 1'b1; d_en = 1'b1; d_wr = 1'b0; d_addr = 32'h08;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            check("auto_count", rdat, 32'(2 - (((k - 1) / 4) % 3)));
        end
        @(posedge clk); #1 d_sel = 1'b0; d_en = 1'b0;
        check("auto_irq", {31'b0, irq0}, 32'd0);
        apb_write(32'h00, 32'h0, 4'hF);
        apb_read(32'h10, v); check("auto_status", v, 32'h1);
        apb_write(32'h10, 32'h1, 4'hF);

        // Byte strobes
        apb_write(32'h04, 32'hFFFF_FFFF, 4'hF);
        apb_write(32'h04, 32'h1234_5678, 4'h1);
`ifdef APB_TIMER_WSTRB_EN
        apb_read(32'h04, v); check("strb_load", v, 32'hFFFF_FF78);
        apb_read(32'h08, v); check("strb_count", v, 32'hFFFF_FF78);
`else
        apb_read(32'h04, v); check("strb_load", v, 32'h1234_5678);
        apb_read(32'h08, v); check("strb_count", v, 32'h1234_5678);
`endif

        // Unused offsets
        apb_write(32'h14, 32'hDEAD_BEEF, 4'hF);
        apb_read(32'h14, v); check("unused_14", v, 32'h0);
        apb_read(32'h1C, v); check("unused_1c", v, 32'h0);

        // Wait-state instance
        tgt = 1'b1;
        apb_write(32'h04, 32'h33, 4'hF);
        d_sel = 1'b1; d_en = 1'b0; d_wr = 1'b0; d_addr = 32'h08;
        @(posedge clk); #1 d_en = 1'b1;
        @(negedge clk); check("ws_ready_1", {31'b0, rdy}, 32'd0);
        @(negedge clk); check("ws_ready_2", {31'b0, rdy}, 32'd0);
        check("ws_state_acc", {31'b0, dbg2}, 32'd1);
        @(negedge clk); check("ws_ready_3", {31'b0, rdy}, 32'd1);
        check("ws_rdata", rdat, 32'h33);
        @(posedge clk); #1 d_sel = 1'b0; d_en = 1'b0;
        d_sel = 1'b1; d_wr = 1'b1; d_addr = 32'h04; d_wdata = 32'h55;
        @(posedge clk); #1 d_en = 1'b1;
        @(negedge clk); check("ws_abort_ready", {31'b0, rdy}, 32'd0);
        @(posedge clk); #1 d_sel = 1'b0; d_en = 1'b0; d_wr = 1'b0;
        apb_read(32'h04, v); check("ws_abort_load", v, 32'h33);
        check("ws_irq", {31'b0, irq2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
